load_store_unit: RTL

//  Memory-stage front end for the data memory: accepts RV32I load/store requests, converts them to word accesses.

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end that turns byte/half/word requests into word accesses on a synchronous-read data memory.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and return resp_err.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [31:0]       mem_rd
);
  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, RESP} state_t;
  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic              mem_wen_q, mem_wen_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mis;
  logic [4:0]        sh;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_data, mask, st_data, merged;
`ifdef MISALIGN_TRAP_EN
  assign mis = (~req_funct3[1] & req_funct3[0] & req_addr[0]) | (req_funct3[1] & (req_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif
  assign req_ready  = (state_q == IDLE) & rst_n;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign mem_wen    = mem_wen_q;
  assign mem_ren    = mem_ren_q;
  // lane extraction for loads and lane merge for sub-word stores, both from the word read in RDWAIT
  always_comb begin
    sh      = {lane_q, 3'b000};
    rd_byte = 8'(mem_rd >> sh);
    rd_half = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    ld_data = f3_q[1] ? mem_rd :
              f3_q[0] ? {{16{~f3_q[2] & rd_half[15]}}, rd_half} :
                        {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
    mask    = f3_q[0] ? (lane_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : (32'h0000_00FF << sh);
    st_data = f3_q[0] ? {2{wdata_q}} : {4{wdata_q[7:0]}};
    merged  = (mem_rd & ~mask) | (st_data & mask);
  end
  // next-state and registered output values; memory strobes and resp pulses default low
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    mem_wen_d    = 1'b0;
    mem_ren_d    = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d       = req_we;
        f3_d       = req_funct3;
        lane_d     = req_addr[1:0];
        wdata_d    = req_wdata[15:0];
        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
        if (mis) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else if (req_we && req_funct3[1]) begin
          state_d   = WR;
          mem_wen_d = 1'b1;
          mem_wd_d  = req_wdata;
        end else begin
          state_d   = RD;
          mem_ren_d = 1'b1;
        end
      end
      RD: state_d = RDWAIT;
      RDWAIT: if (we_q) begin
        state_d   = WR;
        mem_wen_d = 1'b1;
        mem_wd_d  = merged;
      end else begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; async reset aborts any access and drops the memory strobes at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      mem_wen_q    <= mem_wen_d;
      mem_ren_q    <= mem_ren_d;
    end
  end
endmodule
